universal_register_n: RTL and testbench



---
 rtl/universal_register_n_if.sv | 14 +
 rtl/universal_register_n.sv | 67 ++++++
 tb/tb_universal_register_n.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/universal_register_n_if.sv
// universal_register_n_if: control/data bundle (en, mode, d, serial_in -> q, q_bar, serial_out, tc, zero)
interface universal_register_n_if #(parameter int WIDTH = 8);
  logic en;
  logic [2:0] mode;
  logic [WIDTH-1:0] d;
  logic serial_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic serial_out;
  logic tc;
  logic zero;
  modport master(output en, mode, d, serial_in, input q, q_bar, serial_out, tc, zero);
  modport slave(input en, mode, d, serial_in, output q, q_bar, serial_out, tc, zero);
endinterface

// File: rtl/universal_register_n.sv
// universal_register_n: WIDTH-bit load/shift/rotate/count register; ports clk, reset (sync high), bus.slave (en, mode, d, serial_in in; q, q_bar, serial_out, tc, zero out)
module universal_register_n #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit SATURATE = 1'b0
) (
  input logic clk,
  input logic reset,
  universal_register_n_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] q_r, q_nxt;
  logic so_r, so_nxt, tc_r, tc_nxt;
  logic ones, nil;
  assign ones = &q_r;
  assign nil = ~|q_r;
  always_comb begin
    q_nxt = q_r;
    so_nxt = so_r;
    tc_nxt = 1'b0;
    if (bus.en)
      case (bus.mode)
        3'b001: q_nxt = bus.d;
        3'b010: begin
          q_nxt = {q_r[WIDTH-2:0], bus.serial_in};
          so_nxt = q_r[WIDTH-1];
        end
        3'b011: begin
          q_nxt = {bus.serial_in, q_r[WIDTH-1:1]};
          so_nxt = q_r[0];
        end
        3'b100: begin
          q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          so_nxt = q_r[WIDTH-1];
        end
        3'b101: begin
          q_nxt = {q_r[0], q_r[WIDTH-1:1]};
          so_nxt = q_r[0];
        end
        3'b110: begin
          tc_nxt = ones;
          q_nxt = (SATURATE && ones) ? q_r : q_r + ONE;
        end
        3'b111: begin
          tc_nxt = nil;
          q_nxt = (SATURATE && nil) ? q_r : q_r - ONE;
        end
        default: q_nxt = q_r;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= RESET_VALUE;
      so_r <= 1'b0;
      tc_r <= 1'b0;
    end else begin
      q_r <= q_nxt;
      so_r <= so_nxt;
      tc_r <= tc_nxt;
    end
  end
  assign bus.q = q_r;
  assign bus.q_bar = ~q_r;
  assign bus.serial_out = so_r;
  assign bus.tc = tc_r;
  assign bus.zero = nil;
endmodule

// File: tb/tb_universal_register_n.sv
// tb_universal_register_n: table vectors plus random scoreboard run against wrapping and saturating instances
module tb_universal_register_n;
  typedef struct {
    logic rst;
    logic en;
    logic [2:0] mode;
    logic [7:0] d;
    logic si;
    logic [7:0] q_w;
    logic [7:0] q_s;
    logic so;
    logic tc_w;
    logic tc_s;
  } vec_t;
  typedef struct {
    logic [7:0] q_w;
    logic [7:0] q_s;
    logic so_w;
    logic so_s;
    logic tc_w;
    logic tc_s;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  universal_register_n_if #(.WIDTH(8)) bw();
  universal_register_n_if #(.WIDTH(8)) bs();
  universal_register_n #(.WIDTH(8), .RESET_VALUE(8'hA5), .SATURATE(1'b0)) dut_w (.clk(clk), .reset(reset), .bus(bw.slave));
  universal_register_n #(.WIDTH(8), .RESET_VALUE(8'hA5), .SATURATE(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bs.slave));
  always #5 clk = ~clk;
  exp_t sb[$];
  vec_t tbl[$];
  int tests = 0;
  int fails = 0;
  logic [7:0] mq[2];
  logic mso[2];
  logic mtc[2];
  function automatic vec_t mk(logic rst, logic en, logic [2:0] mode, logic [7:0] d, logic si,
                              logic [7:0] q_w, logic [7:0] q_s, logic so, logic tc_w, logic tc_s);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.d = d; v.si = si;
    v.q_w = q_w; v.q_s = q_s; v.so = so; v.tc_w = tc_w; v.tc_s = tc_s;
    return v;
  endfunction
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(logic rst, logic en, logic [2:0] mode, logic [7:0] d, logic si);
    @(negedge clk);
    reset = rst;
    bw.en = en; bw.mode = mode; bw.d = d; bw.serial_in = si;
    bs.en = en; bs.mode = mode; bs.d = d; bs.serial_in = si;
  endtask
  task automatic collect();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    chk("q_wrap", bw.q, e.q_w);
    chk("q_sat", bs.q, e.q_s);
    chk("so_wrap", 8'(bw.serial_out), 8'(e.so_w));
    chk("so_sat", 8'(bs.serial_out), 8'(e.so_s));
    chk("tc_wrap", 8'(bw.tc), 8'(e.tc_w));
    chk("tc_sat", 8'(bs.tc), 8'(e.tc_s));
    chk("qbar_wrap", bw.q_bar, ~e.q_w);
    chk("qbar_sat", bs.q_bar, ~e.q_s);
    chk("zero_wrap", 8'(bw.zero), 8'(e.q_w == 8'h00));
    chk("zero_sat", 8'(bs.zero), 8'(e.q_s == 8'h00));
  endtask
  task automatic mstep(int k, logic rst, logic en, logic [2:0] mode, logic [7:0] d, logic si);
    logic [7:0] c;
    c = mq[k];
    if (rst) begin
      mq[k] = 8'hA5; mso[k] = 1'b0; mtc[k] = 1'b0;
    end else begin
      mtc[k] = 1'b0;
      if (en)
        case (mode)
          3'd1: mq[k] = d;
          3'd2: begin mso[k] = c[7]; mq[k] = {c[6:0], si}; end
          3'd3: begin mso[k] = c[0]; mq[k] = {si, c[7:1]}; end
          3'd4: begin mso[k] = c[7]; mq[k] = {c[6:0], c[7]}; end
          3'd5: begin mso[k] = c[0]; mq[k] = {c[0], c[7:1]}; end
          3'd6: if (c == 8'hFF) begin mtc[k] = 1'b1; mq[k] = (k == 0) ? 8'h00 : 8'hFF; end else mq[k] = c + 8'd1;
          3'd7: if (c == 8'h00) begin mtc[k] = 1'b1; mq[k] = (k == 0) ? 8'hFF : 8'h00; end else mq[k] = c - 8'd1;
          default: ;
        endcase
    end
  endtask
  initial begin
    exp_t e;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'hA5, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'd6, 8'h00, 0, 8'hA5, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 8'h3C, 0, 8'h3C, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 8'hFF, 1, 8'h3C, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 8'h81, 0, 8'h81, 8'h81, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd2, 8'h00, 0, 8'h02, 8'h02, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h01, 8'h01, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h80, 8'h80, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h40, 8'h40, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h20, 8'h20, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h10, 8'h10, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h08, 8'h08, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h04, 8'h04, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h02, 8'h02, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h01, 8'h01, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 8'h81, 0, 8'h81, 8'h81, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd3, 8'h00, 1, 8'hC0, 8'hC0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd3, 8'h00, 0, 8'h60, 8'h60, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd4, 8'h00, 0, 8'hC0, 8'hC0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd4, 8'h00, 0, 8'h81, 8'h81, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd4, 8'h00, 0, 8'h81, 8'h81, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 8'hFE, 0, 8'hFE, 8'hFE, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 8'h00, 0, 8'hFF, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 8'h00, 0, 8'h00, 8'hFF, 1, 1, 1));
    tbl.push_back(mk(0, 1, 3'd6, 8'h00, 0, 8'h01, 8'hFF, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd1, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd7, 8'h00, 0, 8'hFF, 8'h00, 1, 1, 1));
    tbl.push_back(mk(0, 1, 3'd7, 8'h00, 0, 8'hFE, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 1, 3'd1, 8'h10, 0, 8'h10, 8'h10, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 8'h00, 0, 8'h11, 8'h11, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd6, 8'h00, 0, 8'h11, 8'h11, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 8'h00, 0, 8'h12, 8'h12, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 8'hFF, 0, 8'hFF, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd6, 8'h00, 0, 8'h00, 8'hFF, 1, 1, 1));
    tbl.push_back(mk(0, 0, 3'd6, 8'h00, 0, 8'h00, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'd1, 8'hFF, 0, 8'hFF, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3'd6, 8'h00, 0, 8'hA5, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd0, 8'h00, 0, 8'hA5, 8'hA5, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      e.q_w = tbl[i].q_w; e.q_s = tbl[i].q_s; e.so_w = tbl[i].so; e.so_s = tbl[i].so;
      e.tc_w = tbl[i].tc_w; e.tc_s = tbl[i].tc_s;
      sb.push_back(e);
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].si);
      collect();
    end
    for (int i = 0; i < 1000; i++) begin
      logic r, en, si;
      logic [2:0] m;
      logic [7:0] d;
      r = (i == 0) || ($urandom_range(0, 63) == 0);
      en = $urandom_range(0, 3) != 0;
      m = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00) : 8'($urandom);
      si = 1'($urandom);
      for (int k = 0; k < 2; k++) mstep(k, r, en, m, d, si);
      e.q_w = mq[0]; e.q_s = mq[1]; e.so_w = mso[0]; e.so_s = mso[1]; e.tc_w = mtc[0]; e.tc_s = mtc[1];
      sb.push_back(e);
      drive(r, en, m, d, si);
      collect();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
